// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_pkg
// Description : Shared constants and helpers for the CIC decimation filter.
//               Holds the default WIDTH/R/N/M configuration and a function
//               giving the register width required so that the modular
//               integrator/comb arithmetic is exact:
//                   Bin + N * ceil(log2(R*M))
// Revision    : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int C_WIDTH = 16;
    localparam int C_R     = 4;
    localparam int C_N     = 3;
    localparam int C_M     = 1;

    // ceil(log2(value)) for value >= 1; returns 0 for value == 1.
    function automatic int cic_clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Register width needed by both integrator and comb so that the
    // filter gain (R*M)^N never loses information.
    function automatic int cic_reg_width(input int bin, input int n,
                                         input int r, input int m);
        return bin + n * cic_clog2(r * m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_comb_stage.sv
`default_nettype none
// ============================================================================
// Module      : cic_comb_stage
// Description : One comb (differentiator) stage: y = x - x[-M], modulo
//               2^WIDTH. The M-deep delay line advances only on valid
//               samples; the difference and its valid are registered.
// Ports       : clk       - clock, posedge
//               rst       - synchronous active-high reset
//               in_valid  - stage input valid
//               in_data   - stage input sample x
//               out_valid - registered valid (bubbles pass through)
//               out_data  - registered difference, held between strobes
// Revision    : 1.0 - initial release
// ============================================================================
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int M     = C_M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // r_dly[0] is the most recent valid input, r_dly[M-1] is x[-M].
    logic [WIDTH-1:0] r_dly [M];
    logic [WIDTH-1:0] w_diff;

    // Plain WIDTH-bit subtraction: wraps naturally, borrow is discarded.
    assign w_diff = in_data - r_dly[M-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                r_dly[i] <= '0;
            end
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r_dly[0] <= in_data;
                for (int i = 1; i < M; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
                out_data <= w_diff;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cic_comb_decimator.sv
`default_nettype none
// ============================================================================
// Module      : cic_comb_decimator
// Description : CIC decimator back end. Keeps every R-th valid sample of
//               the (wrapped) integrator stream and passes it through N
//               pipelined comb stages with differential delay M. All
//               arithmetic is modulo 2^WIDTH. Latency from accepted sample
//               to out_valid is 1 + N cycles.
// Ports       : clk       - clock, posedge
//               rst       - synchronous active-high reset
//               in_valid  - in_data valid this cycle (gaps allowed)
//               in_data   - integrator output sample
//               out_valid - one-cycle output strobe
//               out_data  - comb cascade output, held between strobes
// Options     : CIC_COMB_WARMUP_EN - when defined, out_valid is suppressed
//               for the first N*M decimated outputs after reset (out_data
//               still updates during that window).
// Revision    : 1.0 - initial release
// ============================================================================
module cic_comb_decimator
    import cic_pkg::*;
#(
    parameter int WIDTH = C_WIDTH,
    parameter int R     = C_R,
    parameter int N     = C_N,
    parameter int M     = C_M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // A one-bit counter is kept for R=1 so the logic stays uniform; it
    // simply never leaves 0.
    localparam int              CNT_W      = (R > 1) ? $clog2(R) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(R - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_keep;
    logic             r_v0;
    logic [WIDTH-1:0] r_d0;

    // Stage k reads index k and drives index k+1.
    logic             w_valid [0:N];
    logic [WIDTH-1:0] w_data  [0:N];

    // ------------------------------------------------------------------
    // Decimation: advance on valid only, keep the sample at phase R-1.
    // ------------------------------------------------------------------
    assign w_keep = in_valid && (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_v0  <= 1'b0;
            r_d0  <= '0;
        end else begin
            if (in_valid) begin
                if (r_cnt == C_CNT_LAST) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            r_v0 <= w_keep;
            if (w_keep) begin
                r_d0 <= in_data;
            end
        end
    end

    assign w_valid[0] = r_v0;
    assign w_data[0]  = r_d0;

    // ------------------------------------------------------------------
    // Comb cascade
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            cic_comb_stage #(
                .WIDTH (WIDTH),
                .M     (M)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (w_valid[k]),
                .in_data   (w_data[k]),
                .out_valid (w_valid[k+1]),
                .out_data  (w_data[k+1])
            );
        end
    endgenerate

    assign out_data = w_data[N];

`ifdef CIC_COMB_WARMUP_EN
    // Saturating count of cascade outputs; strobes are released once the
    // delay lines hold only real samples (N*M outputs after reset).
    localparam int                C_WARM   = N * M;
    localparam int                WARM_W   = $clog2(C_WARM + 1);
    localparam logic [WARM_W-1:0] C_WARM_V = WARM_W'(C_WARM);

    logic [WARM_W-1:0] r_warm;
    logic              w_warm_done;

    assign w_warm_done = (r_warm == C_WARM_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_warm <= '0;
        end else if (w_valid[N] && !w_warm_done) begin
            r_warm <= r_warm + 1'b1;
        end
    end

    assign out_valid = w_valid[N] && w_warm_done;
`else
    assign out_valid = w_valid[N];
`endif

endmodule
`default_nettype wire
